// File: rtl/text_frame_serializer.sv
// Buffers FRAME_LEN bytes, then sends SYNC, payload, checksum as MSB-first NRZ, BIT_DIV clocks/bit.
// Latency: first bit 1 clk after last accept; byte_ready is low for the whole transmission.
module text_frame_serializer #(
    parameter int          FRAME_LEN = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'h7E,
    parameter int          BIT_DIV   = 4,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             tx_bit,
    output logic             bit_strobe,
    output logic             frame_active,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_SYNC,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         chk_q, chk_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               byte_ready_q, byte_ready_d;
    logic               frame_done_q, frame_done_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic [7:0]         mem_q [FRAME_LEN];

    logic       accept;
    logic [7:0] cur_byte;

    // byte_ready_q is only ever high in FILL, so it alone qualifies the handshake.
    assign accept = byte_valid && byte_ready_q;

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (state_q)
            S_PAYLOAD: cur_byte = mem_q[idx_q];
            S_CHK:     cur_byte = chk_q;
            default:   cur_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        bit_cnt_d     = bit_cnt_q;
        div_d         = div_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        if (state_q == S_FILL) begin
            if (accept) begin
                chk_d = chk_q + byte_in;
                if (idx_q == IDX_LAST) begin
                    state_d   = S_SYNC;
                    idx_d     = '0;
                    bit_cnt_d = '0;
                    div_d     = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end else if (div_q == DIV_LAST) begin
            div_d     = '0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    S_SYNC: state_d = S_PAYLOAD;
                    S_PAYLOAD: begin
                        if (idx_q == IDX_LAST) state_d = S_CHK;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end
                    default: begin
                        state_d       = S_FILL;
                        idx_d         = '0;
                        chk_d         = '0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + CNT_W'(1);
                    end
                endcase
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        byte_ready_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_FILL;
            idx_q         <= '0;
            chk_q         <= '0;
            bit_cnt_q     <= '0;
            div_q         <= '0;
            byte_ready_q  <= 1'b1;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            bit_cnt_q     <= bit_cnt_d;
            div_q         <= div_d;
            byte_ready_q  <= byte_ready_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Payload storage needs no reset: a reset restarts filling from index 0.
    always_ff @(posedge clk) begin
        if (accept) mem_q[idx_q] <= byte_in;
    end

    assign byte_ready   = byte_ready_q;
    assign frame_active = (state_q != S_FILL);
    assign tx_bit       = (state_q == S_FILL) ? 1'b1 : cur_byte[3'd7 - bit_cnt_q];
    assign bit_strobe   = (state_q != S_FILL) && (div_q == '0);
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_text_frame_serializer.sv
// Scoreboard bench: stimulus pushes expected frame bytes, negedge monitors deserialize tx_bit and compare.
// Instance a uses default parameters; instance b uses FRAME_LEN=1, BIT_DIV=1.
module tb_text_frame_serializer;

    logic        clk;
    logic        rst_a, rst_b;
    logic [7:0]  byte_in_a, byte_in_b;
    logic        byte_valid_a, byte_valid_b;
    logic        byte_ready_a, byte_ready_b;
    logic        tx_bit_a, tx_bit_b;
    logic        bit_strobe_a, bit_strobe_b;
    logic        frame_active_a, frame_active_b;
    logic        frame_done_a, frame_done_b;
    logic [15:0] frame_count_a, frame_count_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int   frames_a = 0, frames_b = 0;
    int   act_a = 0, act_b = 0, nb_a = 0, nb_b = 0, gap_a = 0;
    int   sbad_a = 0, sbad_b = 0;
    logic [7:0] sh_a = 8'h00, sh_b = 8'h00;
    logic prev_a = 1'b0, prev_b = 1'b0, last_a = 1'b1;
    logic abort_a = 1'b0;

    text_frame_serializer dut_a (
        .clk(clk), .reset(rst_a), .byte_in(byte_in_a), .byte_valid(byte_valid_a),
        .byte_ready(byte_ready_a), .tx_bit(tx_bit_a), .bit_strobe(bit_strobe_a),
        .frame_active(frame_active_a), .frame_done(frame_done_a), .frame_count(frame_count_a)
    );

    text_frame_serializer #(.FRAME_LEN(1), .SYNC_BYTE(8'h7E), .BIT_DIV(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst_b), .byte_in(byte_in_b), .byte_valid(byte_valid_b),
        .byte_ready(byte_ready_b), .tx_bit(tx_bit_b), .bit_strobe(bit_strobe_b),
        .frame_active(frame_active_b), .frame_done(frame_done_b), .frame_count(frame_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor a: deserialize, check bit timing, frame length, frame_done and count.
    always @(negedge clk) begin
        if (frame_active_a) begin
            act_a++;
            if (bit_strobe_a) begin
                if (act_a > 1 && gap_a != 4) sbad_a++;
                gap_a = 1;
                sh_a  = {sh_a[6:0], tx_bit_a};
                nb_a++;
                if (nb_a == 8) begin
                    nb_a = 0;
                    if (qa.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL a_byte: got %h, expected nothing", sh_a);
                    end else begin
                        check("a_byte", sh_a, qa.pop_front());
                    end
                end
            end else begin
                if (act_a == 1) sbad_a++;
                gap_a++;
                if (tx_bit_a !== last_a) sbad_a++;
            end
            last_a = tx_bit_a;
        end else begin
            if (tx_bit_a !== 1'b1) sbad_a++;
            if (prev_a) begin
                if (abort_a) begin
                    abort_a = 1'b0;
                    qa.delete();
                end else begin
                    check("a_frame_len", act_a, 576);
                    check("a_frame_done", frame_done_a, 1);
                    frames_a++;
                    check("a_frame_count", frame_count_a, frames_a);
                end
                act_a = 0;
                nb_a  = 0;
            end
        end
        prev_a = frame_active_a;
    end

    // Monitor b: every active cycle must carry a strobe.
    always @(negedge clk) begin
        if (frame_active_b) begin
            act_b++;
            if (bit_strobe_b !== 1'b1) sbad_b++;
            sh_b = {sh_b[6:0], tx_bit_b};
            nb_b++;
            if (nb_b == 8) begin
                nb_b = 0;
                if (qb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_byte: got %h, expected nothing", sh_b);
                end else begin
                    check("b_byte", sh_b, qb.pop_front());
                end
            end
        end else if (prev_b) begin
            check("b_frame_len", act_b, 24);
            check("b_frame_done", frame_done_b, 1);
            frames_b++;
            check("b_frame_count", frame_count_b, frames_b);
            act_b = 0;
            nb_b  = 0;
        end
        prev_b = frame_active_b;
    end

    task automatic send_a(input logic [7:0] b, input int gap, output logic fd);
        logic acc;
        byte_valid_a = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in_a    = b;
        byte_valid_a = 1'b1;
        acc = 1'b0;
        fd  = 1'b0;
        for (int n = 0; n < 2000 && !acc; n++) begin
            acc = byte_ready_a;
            fd  = frame_done_a;
            @(negedge clk);
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL a_accept_timeout: byte %h not accepted", b);
        end
    endtask

    task automatic feed_a(input logic [7:0] base, input logic [7:0] step, input bit gaps,
                          input logic [7:0] exp_chk, input bit want_fd);
        logic [7:0] d;
        logic fd;
        qa.push_back(8'h7E);
        for (int i = 0; i < 16; i++) begin
            d = base + 8'(i) * step;
            send_a(d, gaps ? int'($urandom_range(0, 3)) : 0, fd);
            if (i == 0 && want_fd) check("a_first_accept_in_done_cycle", fd, 1);
            qa.push_back(d);
        end
        byte_valid_a = 1'b0;
        qa.push_back(exp_chk);
    endtask

    task automatic wait_frames_a(input int target);
        for (int n = 0; n < 3000 && frames_a < target; n++) @(negedge clk);
        check("a_frames_seen", frames_a, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rbad;
        rst_a = 1'b0; rst_b = 1'b0;
        byte_in_a = 8'hAA; byte_valid_a = 1'b1;
        byte_in_b = 8'h00; byte_valid_b = 1'b0;

        // reset held 3 clocks with byte_valid high
        repeat (3) @(negedge clk);
        check("rst_byte_ready", byte_ready_a, 1);
        check("rst_tx_bit", tx_bit_a, 1);
        check("rst_frame_active", frame_active_a, 0);
        check("rst_bit_strobe", bit_strobe_a, 0);
        check("rst_frame_done", frame_done_a, 0);
        check("rst_frame_count", frame_count_a, 0);
        byte_valid_a = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // FRAME_LEN=1, BIT_DIV=1: 24 bits, strobe every clock
        qb.push_back(8'h7E); qb.push_back(8'h3C); qb.push_back(8'h3C);
        byte_in_b = 8'h3C; byte_valid_b = 1'b1;
        @(negedge clk);
        byte_valid_b = 1'b0;
        for (int n = 0; n < 100 && frames_b < 1; n++) @(negedge clk);
        check("b_frames_seen", frames_b, 1);
        check("b_queue_empty", qb.size(), 0);
        check("b_strobe_every_cycle", sbad_b, 0);

        // abort during bit 3 of payload byte 5 (cycle 205 of the frame)
        feed_a(8'h20, 8'h01, 1'b0, 8'h78, 1'b0);
        repeat (205) @(negedge clk);
        check("abort_pre_active", frame_active_a, 1);
        abort_a = 1'b1;
        rst_a   = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check("abort_tx_bit", tx_bit_a, 1);
        check("abort_frame_active", frame_active_a, 0);
        check("abort_byte_ready", byte_ready_a, 1);
        rbad = 0;
        for (int n = 0; n < 4; n++) begin
            if (frame_done_a !== 1'b0) rbad++;
            @(negedge clk);
        end
        check("abort_no_frame_done", rbad, 0);
        check("abort_frame_count", frame_count_a, 0);

        // basic frame 0x01..0x10, checksum 0x88
        feed_a(8'h01, 8'h01, 1'b0, 8'h88, 1'b0);
        wait_frames_a(1);

        // 0xFF x16 with gaps, checksum 0xF0; bytes offered during tx are refused
        feed_a(8'hFF, 8'h00, 1'b1, 8'hF0, 1'b0);
        byte_in_a = 8'h99; byte_valid_a = 1'b1;
        rbad = 0;
        for (int n = 0; n < 576; n++) begin
            if (byte_ready_a !== 1'b0) rbad++;
            @(negedge clk);
        end
        check("tx_byte_ready_low", rbad, 0);

        // back-to-back frames 0xA0.. then 0xB0.., each checksum 0x78
        feed_a(8'hA0, 8'h01, 1'b0, 8'h78, 1'b1);
        feed_a(8'hB0, 8'h01, 1'b0, 8'h78, 1'b1);
        wait_frames_a(4);
        repeat (2) @(negedge clk);
        check("a_queue_empty", qa.size(), 0);
        check("a_bit_timing", sbad_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
